sel_pipe_mux: RTL and testbench
===============================

# sel_pipe_mux

Parametrised, registered N-channel selector that replaces the fixed 16-bit combinational multiplexers on datapath operand and result paths where the source must be flow-controlled. It has two selection modes: directed select, driven by a control-unit select code, and round-robin arbitration among requesting channels. The chosen word is captured into a single output register with a valid/ready handshake, and the granted channel index is reported alongside it. Channel 0..N-1 ordering and out-of-range select handling match the existing select-code convention: a code ≥ N-1 selects channel N-1.

## Interface
- WIDTH, 16: data width per channel.
- N, 6: number of input channels, 2..16.
- SEL_W: derived as $clog2(N), not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i holds a word.
- in_ready  output  N  channel i word is accepted this cycle; one-hot or zero.
- mode  input  1  0 = directed select; 1 = round-robin.
- sel  input  SEL_W  channel code used in mode 0.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  channel index of out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  downstream accepts the word.

## Operation
- State: output register {out_valid, out_data, out_chan}; round-robin pointer rr_ptr (SEL_W bits, range 0..N-1).
- load_en = !out_valid || out_ready.
- Grant selection is combinational from in_valid, mode, sel and rr_ptr.
- Mode 0:
  - Target channel t = min(sel, N-1).
  - A grant exists only if in_valid[t]=1. Other channels are never granted, even if valid.
- Mode 1:
  - Grant goes to the first channel with in_valid=1, scanning rr_ptr, rr_ptr+1, … mod N.
  - No grant if in_valid is all zero.
- Input transfer:
  - in_ready[g] = load_en && grant_exists && !rst. All other in_ready bits are 0.
  - A transfer occurs on channel g when in_valid[g] && in_ready[g].
- On an input transfer: out_data ← word of channel g, out_chan ← g, out_valid ← 1, rr_ptr ← (g+1) mod N. The pointer updates in both modes, so switching modes is well-defined.
- Output drain: out_valid && out_ready with no new transfer → out_valid ← 0. out_data and out_chan keep their last values.
- Simultaneous drain and load in one cycle: the new word replaces the old one, and out_valid stays 1. This gives full throughput with no bubble.
- Stall (out_valid && !out_ready):
  - in_ready is all zero.
  - out_data and out_chan are held stable.
  - Changes to mode, sel or in_valid have no effect on the held word.
- Wrap-around: rr_ptr at N-1 with a grant → next value 0.

## Timing
- Reset (async assert, takes effect immediately): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, in_ready=0.
- Reset release is synchronous to clk from the first rising edge after rst falls. The block accepts a word on that first edge if a grant exists.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: one word per cycle while out_ready=1.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. There are no combinational paths from in_data to any output.
- Reset mid-stall: the held word is discarded, out_valid=0, and no in_ready is asserted during reset.

## Test plan
- Reset, then mode=0, sel=2, in_valid=6'b000100, ch2=16'hA5A5, out_ready=1 → in_ready=6'b000100; next cycle out_data=16'hA5A5, out_chan=2, out_valid=1.
- Mode=0, sel=7, N=6, in_valid=6'b100001 → channel 5 is granted, out_chan=5; with in_valid=6'b000001 and sel=7, no grant and in_ready=0.
- Mode=1, all six channels valid, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,4,5,0,1 with out_valid continuously 1.
- Stall: out_valid=1 holding ch3 word, out_ready=0 for 4 cycles while sel and in_data change → in_ready=0 and out_data/out_chan unchanged. Raise out_ready → the held word drains and the next grant loads in the same cycle.
- Assert rst asynchronously mid-stall (between edges) → out_valid, out_data, out_chan and in_ready go to 0 immediately. After release in mode 1 with in_valid=6'b010000 → rr_ptr starts at 0 and channel 4 is granted.

Source files
------------

// File: rtl/sel_pipe_mux.sv
`default_nettype none
// ============================================================================
// Module   : sel_pipe_mux
// Brief    : Registered N-channel selector, directed-select or round-robin,
//            with valid/ready handshake on both sides.
// Revision : 1.0
// ============================================================================
module sel_pipe_mux #(
  parameter  int WIDTH = 16,
  parameter  int N     = 6,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SEL_W-1:0] c_last = SEL_W'(N - 1);
  localparam logic [SEL_W:0]   c_n    = (SEL_W + 1)'(N);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load_en;
  logic             w_grant;
  logic             w_xfer;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_tgt;
  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_ptr_nxt;

  assign w_load_en = !r_out_valid || out_ready;

  always_comb begin
    w_grant   = 1'b0;
    w_gnt_idx = '0;
    w_tgt     = '0;
    w_sum     = '0;
    if (!mode) begin
      // Codes past the last channel clamp to it, matching the legacy mux.
      w_tgt     = (sel > c_last) ? c_last : sel;
      w_gnt_idx = w_tgt;
      w_grant   = in_valid[w_tgt];
    end else begin
      // Scan from the far end so the channel nearest rr_ptr is the last to win.
      for (int k = N - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
        if (w_sum >= c_n) begin
          w_sum = w_sum - c_n;
        end
        if (in_valid[w_sum[SEL_W-1:0]]) begin
          w_grant   = 1'b1;
          w_gnt_idx = w_sum[SEL_W-1:0];
        end
      end
    end
  end

  assign w_xfer    = w_grant && w_load_en;
  assign w_ptr_nxt = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
  assign in_ready  = (w_xfer && !rst) ? (N'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
      r_out_chan  <= w_gnt_idx;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_sel_pipe_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_sel_pipe_mux
// Brief    : Directed self-checking bench for sel_pipe_mux (WIDTH=16, N=6).
// Revision : 1.0
// ============================================================================
module tb_sel_pipe_mux;

  localparam int WIDTH = 16;
  localparam int N     = 6;
  localparam int SEL_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  sel_pipe_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [WIDTH-1:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid = 6'b111111;
    for (int i = 0; i < N; i++) set_ch(i, 16'hBEEF);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", out_data); end
    n_checks++;
    if (out_chan !== 3'd0) begin n_fail++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    n_checks++;
    if (in_ready !== 6'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 000000", in_ready); end
    in_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    mode = 1'b0; sel = 3'd2; out_ready = 1'b1;
    set_ch(2, 16'hA5A5);
    in_valid = 6'b000100;
    #1;
    n_checks++;
    if (in_ready !== 6'b000100) begin n_fail++; $display("FAIL dir_in_ready got %b want 000100", in_ready); end
    tick();
    n_checks++;
    if (out_data !== 16'hA5A5 || out_chan !== 3'd2 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL dir_out got %h/%0d/%b want a5a5/2/1", out_data, out_chan, out_valid);
    end
    in_valid = '0;
    #1;
    n_checks++;
    if (in_ready !== 6'b0) begin n_fail++; $display("FAIL dir_idle_ready got %b want 000000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hA5A5 || out_chan !== 3'd2) begin
      n_fail++; $display("FAIL dir_drain got %h/%0d/%b want a5a5/2/0", out_data, out_chan, out_valid);
    end
  endtask

  task automatic test_clamp();
    mode = 1'b0; sel = 3'd7;
    set_ch(0, 16'h0F0F);
    set_ch(5, 16'h5555);
    in_valid = 6'b100001;
    #1;
    n_checks++;
    if (in_ready !== 6'b100000) begin n_fail++; $display("FAIL clamp_ready got %b want 100000", in_ready); end
    tick();
    n_checks++;
    if (out_data !== 16'h5555 || out_chan !== 3'd5 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL clamp_out got %h/%0d/%b want 5555/5/1", out_data, out_chan, out_valid);
    end
    in_valid = 6'b000001;
    #1;
    n_checks++;
    if (in_ready !== 6'b0) begin n_fail++; $display("FAIL clamp_nogrant got %b want 000000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_round_robin();
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 16'h1000 + 16'(i));
    in_valid = 6'b111111;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (out_chan !== 3'(c % N) || out_valid !== 1'b1 || out_data !== 16'h1000 + 16'(c % N)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d] got %0d/%h/%b want %0d/%h/1", c, out_chan, out_data, out_valid,
                 c % N, 16'h1000 + 16'(c % N));
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    mode = 1'b0; sel = 3'd3; out_ready = 1'b1;
    set_ch(3, 16'h3333);
    in_valid = 6'b111111;
    tick();
    n_checks++;
    if (out_data !== 16'h3333 || out_chan !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_load got %h/%0d/%b want 3333/3/1", out_data, out_chan, out_valid);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sel = 3'(c);
      for (int i = 0; i < N; i++) set_ch(i, 16'hD000 + 16'(c * 16 + i));
      #1;
      n_checks++;
      if (in_ready !== 6'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 000000", c, in_ready); end
      tick();
      n_checks++;
      if (out_data !== 16'h3333 || out_chan !== 3'd3 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got %h/%0d/%b want 3333/3/1", c, out_data, out_chan, out_valid);
      end
    end
    sel = 3'd1;
    set_ch(1, 16'h1111);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 6'b000010) begin n_fail++; $display("FAIL stall_release_ready got %b want 000010", in_ready); end
    tick();
    n_checks++;
    if (out_data !== 16'h1111 || out_chan !== 3'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_release got %h/%0d/%b want 1111/1/1", out_data, out_chan, out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    // Loading ch3 leaves rr_ptr at 4, so the post-reset scan exposes whether it was cleared.
    mode = 1'b0; sel = 3'd3; out_ready = 1'b1;
    set_ch(3, 16'h3C3C);
    in_valid = 6'b111111;
    tick();
    out_ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_chan !== 3'd0) begin
      n_fail++; $display("FAIL async_rst got %h/%0d/%b want 0000/0/0", out_data, out_chan, out_valid);
    end
    n_checks++;
    if (in_ready !== 6'b0) begin n_fail++; $display("FAIL async_rst_ready got %b want 000000", in_ready); end
    tick();
    rst = 1'b0;
    mode = 1'b1; out_ready = 1'b1;
    in_valid = 6'b110001;
    #1;
    n_checks++;
    if (in_ready !== 6'b000001) begin n_fail++; $display("FAIL rst_ptr got %b want 000001", in_ready); end
    set_ch(4, 16'h4444);
    in_valid = 6'b010000;
    #1;
    n_checks++;
    if (in_ready !== 6'b010000) begin n_fail++; $display("FAIL post_rst_ready got %b want 010000", in_ready); end
    tick();
    n_checks++;
    if (out_data !== 16'h4444 || out_chan !== 3'd4 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_out got %h/%0d/%b want 4444/4/1", out_data, out_chan, out_valid);
    end
    in_valid = 6'b100001;
    #1;
    n_checks++;
    if (in_ready !== 6'b100000) begin n_fail++; $display("FAIL rr_ptr5 got %b want 100000", in_ready); end
    tick();
    #1;
    n_checks++;
    if (in_ready !== 6'b000001) begin n_fail++; $display("FAIL rr_wrap got %b want 000001", in_ready); end
    tick();
    n_checks++;
    if (out_chan !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rr_wrap_out got %0d/%b want 0/1", out_chan, out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_clamp();
    test_round_robin();
    test_stall();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
